// File: rtl/m_clk_pkg.sv
// rtl/m_clk_pkg.sv - shared types and constants for the clock-phase sequencer.
package m_clk_pkg;

  localparam int DIV_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    WAIT = 2'b10,
    LOW  = 2'b11
  } state_t;

endpackage

// File: rtl/m_halfper_cnt.sv
// rtl/m_halfper_cnt.sv - loadable half-period down counter with zero flag.
module m_halfper_cnt #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [DIV_W-1:0] r_cnt;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/m_clk_phase.sv
// rtl/m_clk_phase.sv - drives the S/R strobes of the clock-net NAND latch,
// dividing clk by a programmable half-period with wait-state stretching.
module m_clk_phase
  import m_clk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             wait_req,
  output logic             set_l,
  output logic             rst_l,
  output logic             phase,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic             wait_ack
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_dec;
  logic   w_zero;
  logic   w_rise;
  logic   w_fall;

  logic   r_set_l;
  logic   r_rst_l;
  logic   r_phase;
  logic   r_edge_rise;
  logic   r_edge_fall;
  logic   r_wait_ack;

  m_halfper_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk        (clk),
    .resetl     (resetl),
    .i_load     (w_load),
    .i_load_val (div),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) begin
          w_state_nxt = HIGH;
          w_load      = 1'b1;
          w_rise      = 1'b1;
        end
      end
      HIGH: begin
        if (!w_zero) begin
          w_dec = 1'b1;
        end else if (wait_req) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = LOW;
          w_load      = 1'b1;
          w_fall      = 1'b1;
        end
      end
      WAIT: begin
        if (!wait_req) begin
          w_state_nxt = LOW;
          w_load      = 1'b1;
          w_fall      = 1'b1;
        end
      end
      LOW: begin
        if (!w_zero) begin
          w_dec = 1'b1;
        end else if (run) begin
          w_state_nxt = HIGH;
          w_load      = 1'b1;
          w_rise      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe is glitch-free.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_state     <= IDLE;
      r_set_l     <= 1'b1;
      r_rst_l     <= 1'b0;
      r_phase     <= 1'b0;
      r_edge_rise <= 1'b0;
      r_edge_fall <= 1'b0;
      r_wait_ack  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_set_l     <= ~w_rise;
      r_rst_l     <= ~(w_fall || (w_state_nxt == IDLE));
      r_phase     <= (w_state_nxt == HIGH) || (w_state_nxt == WAIT);
      r_edge_rise <= w_rise;
      r_edge_fall <= w_fall;
      r_wait_ack  <= (w_state_nxt == WAIT);
    end
  end

  assign set_l     = r_set_l;
  assign rst_l     = r_rst_l;
  assign phase     = r_phase;
  assign edge_rise = r_edge_rise;
  assign edge_fall = r_edge_fall;
  assign wait_ack  = r_wait_ack;

endmodule

// File: tb/tb_m_clk_phase.sv
// tb/tb_m_clk_phase.sv - directed and random checks of m_clk_phase against
// a phase-length model of the derived clock.
module tb_m_clk_phase;

  logic       clk;
  logic       resetl;
  logic       run;
  logic [3:0] div;
  logic       wait_req;
  logic       set_l;
  logic       rst_l;
  logic       phase;
  logic       edge_rise;
  logic       edge_fall;
  logic       wait_ack;

  int total;
  int bad;

  // Model: derived clock on/off, current level, phase length and age.
  bit m_on;
  bit m_hi;
  bit m_wait;
  bit e_rise;
  bit e_fall;
  int m_len;
  int m_age;

  m_clk_phase #(
    .DIV_W (4)
  ) dut (
    .clk       (clk),
    .resetl    (resetl),
    .run       (run),
    .div       (div),
    .wait_req  (wait_req),
    .set_l     (set_l),
    .rst_l     (rst_l),
    .phase     (phase),
    .edge_rise (edge_rise),
    .edge_fall (edge_fall),
    .wait_ack  (wait_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_on = 0; m_hi = 0; m_wait = 0; e_rise = 0; e_fall = 0; m_len = 0; m_age = 0;
  endtask

  task automatic begin_phase(input bit hi, input int d);
    m_hi = hi; m_len = d + 1; m_age = 1; m_wait = 0;
    if (hi) e_rise = 1; else e_fall = 1;
  endtask

  task automatic model_step(input bit r, input int d, input bit w);
    e_rise = 0;
    e_fall = 0;
    if (!m_on) begin
      if (r) begin
        m_on = 1;
        begin_phase(1, d);
      end
    end else if (m_age < m_len) begin
      m_age++;
    end else if (m_hi) begin
      if (w) m_wait = 1;
      else begin_phase(0, d);
    end else if (r) begin
      begin_phase(1, d);
    end else begin
      m_on = 0;
      m_hi = 0;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("set_l", set_l, !e_rise);
    chk("rst_l", rst_l, !(e_fall || !m_on));
    chk("phase", phase, m_on && m_hi);
    chk("edge_rise", edge_rise, e_rise);
    chk("edge_fall", edge_fall, e_fall);
    chk("wait_ack", wait_ack, m_wait);
  endtask

  task automatic step();
    @(posedge clk);
    if (!resetl) model_reset();
    else model_step(run, int'(div), wait_req);
    #1;
    check_all();
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int last_rise;
    int hi_cnt;
    int lo_cnt;
    int wa_cnt;
    total = 0;
    bad   = 0;
    resetl = 1'b1; run = 1'b0; div = 4'd0; wait_req = 1'b0;
    model_reset();

    // Reset state, then idle with run low.
    #2 resetl = 1'b0;
    #1 check_all();
    repeat (3) step();
    resetl = 1'b1;
    repeat (6) step();

    // div=2: 6-cycle period, fall strobe 3 cycles after each rise.
    run = 1'b1; div = 4'd2;
    last_rise = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (set_l == 1'b0) begin
        if (last_rise >= 0) chk_int("rise_spacing", c - last_rise, 6);
        last_rise = c;
      end
      if (last_rise >= 0 && c == last_rise + 3) chk("fall_after_rise", rst_l, 1'b0);
    end
    run = 1'b0;
    repeat (8) step();

    // div=0: phase toggles each cycle, strobes never overlap.
    run = 1'b1; div = 4'd0;
    repeat (10) begin
      step();
      chk("no_overlap", set_l | rst_l, 1'b1);
    end
    run = 1'b0;
    repeat (4) step();

    // div=1 with four cycles of wait_req across the end of the high phase.
    run = 1'b1; div = 4'd1;
    hi_cnt = 0; wa_cnt = 0;
    step();
    run = 1'b0;
    hi_cnt += int'(phase);
    step();
    hi_cnt += int'(phase);
    wait_req = 1'b1;
    repeat (4) begin
      step();
      hi_cnt += int'(phase);
      wa_cnt += int'(wait_ack);
    end
    wait_req = 1'b0;
    repeat (6) begin
      step();
      hi_cnt += int'(phase);
      wa_cnt += int'(wait_ack);
    end
    chk_int("wait_ack_cycles", wa_cnt, 4);
    chk_int("stretched_high", hi_cnt, 6);

    // run dropped in first high cycle, div=3: full 4/4 cycle then idle.
    run = 1'b1; div = 4'd3;
    hi_cnt = 0; lo_cnt = 0;
    step();
    run = 1'b0;
    hi_cnt += int'(phase);
    repeat (12) begin
      step();
      hi_cnt += int'(phase);
      lo_cnt += int'(!phase && (rst_l || edge_fall));
    end
    chk_int("drop_high", hi_cnt, 4);
    chk_int("drop_low", lo_cnt, 4);
    chk("idle_hold", rst_l, 1'b0);

    // div change during HIGH only affects the LOW reload.
    run = 1'b1; div = 4'd3;
    hi_cnt = 0; lo_cnt = 0;
    step();
    run = 1'b0; div = 4'd1;
    hi_cnt += int'(phase);
    repeat (10) begin
      step();
      hi_cnt += int'(phase);
      lo_cnt += int'(!phase && (rst_l || edge_fall));
    end
    chk_int("reload_high", hi_cnt, 4);
    chk_int("reload_low", lo_cnt, 2);

    // Asynchronous reset while in WAIT, then restart.
    run = 1'b1; div = 4'd0;
    step();
    wait_req = 1'b1;
    step();
    step();
    chk("in_wait", wait_ack, 1'b1);
    #3 resetl = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) step();
    resetl = 1'b1; wait_req = 1'b0; run = 1'b1;
    step();
    chk("restart_rise", set_l, 1'b0);
    run = 1'b0;
    repeat (6) step();

    // Random run/div/wait_req traffic.
    for (int i = 0; i < 400; i++) begin
      run      = ($urandom_range(0, 3) != 0);
      div      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      wait_req = ($urandom_range(0, 2) == 0);
      step();
      chk("rand_no_overlap", set_l | rst_l, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_clk_phase.md
# m_clk_phase

Clock-phase sequencer that directly drives the set/reset inputs of the NAND SR latch in the clock net. It divides the master clock by a programmable half-period and emits one-cycle active-low set/reset strobes, so the latch output becomes a clean derived clock. It supports stretching the high phase on request (wait states) and parking the derived clock low when idle.

## Interface
- DIV_W, default 4: width of the half-period divisor.
- clk  in  1  master clock; all state changes on rising edge.
- resetl  in  1  reset, asynchronous, active-low.
- run  in  1  enable; derived clock runs while high and parks low after run drops.
- div  in  DIV_W  half-period length minus 1, in clk cycles; sampled at every reload.
- wait_req  in  1  request to stretch the current high phase.
- set_l  out  1  active-low strobe to latch S; one cycle low on each rising edge of the derived clock.
- rst_l  out  1  active-low strobe to latch R; one cycle low on each falling edge; held low while idle.
- phase  out  1  registered copy of the intended latch output (1 = high phase).
- edge_rise  out  1  one-cycle pulse, coincident with set_l low.
- edge_fall  out  1  one-cycle pulse, coincident with a rst_l falling-edge strobe (not idle hold).
- wait_ack  out  1  high for every cycle spent in WAIT.

## Operation
- Four states: IDLE, HIGH, WAIT, LOW. A countdown counter cnt (DIV_W bits) is loaded with div on entry to HIGH and LOW.
- Reset (asynchronous): state=IDLE, cnt=0, set_l=1, rst_l=0, phase=0, edge_rise=0, edge_fall=0, wait_ack=0.
- IDLE: rst_l held 0 (latch cleared). If run=1: go to HIGH, set_l=0 and edge_rise=1 for that one cycle, phase=1, cnt<=div. rst_l returns to 1 on the same edge.
- HIGH: if cnt!=0, cnt decrements. If cnt==0 and wait_req=1: go to WAIT, wait_ack=1. If cnt==0 and wait_req=0: go to LOW, rst_l=0 and edge_fall=1 for one cycle, phase=0, cnt<=div.
- WAIT: stays while wait_req=1, wait_ack=1, phase=1. When wait_req=0: go to LOW as from HIGH; wait_ack=0 on the same edge.
- LOW: if cnt!=0, cnt decrements. If cnt==0 and run=1: go to HIGH as from IDLE. If cnt==0 and run=0: go to IDLE; rst_l goes low and stays low, edge_fall=0.
- wait_req is sampled only in HIGH with cnt==0, and in WAIT. run is sampled only in IDLE and in LOW with cnt==0. If run drops mid-cycle, the current HIGH and LOW phases still complete.
- Invariant: set_l and rst_l are never low in the same cycle. Each strobe is low for exactly one cycle, except rst_l while in IDLE.
- div=0: each phase lasts 1 cycle, giving a derived period of 2 clk cycles. div changes take effect only at the next reload.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- run sampled high at edge k, in IDLE: set_l=0, phase=1 after edge k. The first falling strobe follows edge k+div+1.
- Without waits, half-period = div+1 cycles and period = 2*(div+1) cycles.
- With W cycles of wait_req still high after the high phase's last count, the high phase becomes div+1+W cycles.
- Reset asserted mid-operation: outputs take their reset values immediately, without waiting for a clock edge. A pending wait is dropped with wait_ack=0.

## Structure
- Shared package m_clk_pkg holds:
  - state typedef: IDLE=2'b00, HIGH=2'b01, WAIT=2'b10, LOW=2'b11;
  - DIV_W default constant.
- One natural sub-module, m_halfper_cnt: a loadable DIV_W-bit down counter with load, dec and zero-flag outputs. The FSM and output registers stay in the top module.

## Test plan
- Reset held, then released with run=0 → set_l=1, rst_l=0, phase=0 indefinitely; no edge pulses.
- run=1, div=2, wait_req=0 → set_l pulses every 6 cycles; rst_l pulses 3 cycles after each set_l pulse; phase is a 3-high/3-low square wave.
- div=0, run=1 → phase toggles every cycle; set_l and rst_l pulses alternate and are never both low.
- div=1, wait_req held high for 4 cycles across the end of a high phase → wait_ack high for exactly 4 cycles; high phase = 6 cycles; rst_l strobe on the edge after wait_req falls.
- run dropped on the first cycle of a high phase, div=3 → high phase of 4 cycles and low phase of 4 cycles complete, then IDLE with rst_l held 0. A div change during HIGH applies only at the LOW reload.
- resetl asserted mid-WAIT → set_l=1, rst_l=0, wait_ack=0, phase=0 immediately. After release with run=1, the sequence restarts from IDLE with a set_l pulse.
